// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - parametrised register file with bypassed read ports and hardware clear
//
// Ports:
//   clk      in   clock, all state updates on rising edge
//   Reset    in   synchronous active-high reset
//   WrEn     in   write request (dropped while Busy)
//   WrInc    in   with WrEn: write to internal pointer, then advance pointer
//   WrAddr   in   write address when WrInc=0
//   WrData   in   write data
//   RdAddrA  in   read address, port A
//   RdAddrB  in   read address, port B
//   OutA     out  registered read data, port A (bypasses same-cycle write)
//   OutB     out  registered read data, port B (bypasses same-cycle write)
//   ClrReq   in   start hardware clear of every register
//   Busy     out  clear sequence running
//   ClrDone  out  single-cycle pulse once the clear has finished

module reg_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             WrEn,
  input  logic             WrInc,
  input  logic [AW-1:0]    WrAddr,
  input  logic [WIDTH-1:0] WrData,
  input  logic [AW-1:0]    RdAddrA,
  input  logic [AW-1:0]    RdAddrB,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  input  logic             ClrReq,
  output logic             Busy,
  output logic             ClrDone
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    clr_cnt;

  logic             clr_start;
  logic             clr_step;
  logic             wr_acc;
  logic [AW-1:0]    wr_tgt;

  // Busy and ClrDone are pure decodes of the state register.
  assign Busy    = (state == S_CLEAR);
  assign ClrDone = (state == S_DONE);

  assign wr_acc = WrEn && !Busy;
  assign wr_tgt = WrInc ? ptr : WrAddr;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_start = 1'b0;
    clr_step  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ClrReq) begin
          clr_start = 1'b1;
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        clr_step = 1'b1;
        if (clr_cnt == AW'(DEPTH - 1)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // ClrReq is deliberately not looked at here: requests are not queued.
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      OutA    <= '0;
      OutB    <= '0;
      ptr     <= '0;
      clr_cnt <= '0;
    end else begin
      // wr_acc and clr_step are mutually exclusive (wr_acc needs Busy=0).
      if (wr_acc) begin
        mem[wr_tgt] <= WrData;
      end
      if (clr_step) begin
        mem[clr_cnt] <= '0;
        clr_cnt      <= clr_cnt + AW'(1);
      end

      // Starting a clear rewinds the pointer even if an auto-increment
      // write lands in the same cycle.
      if (clr_start) begin
        clr_cnt <= '0;
        ptr     <= '0;
      end else if (wr_acc && WrInc) begin
        ptr <= ptr + AW'(1);
      end

      // Only accepted host writes are forwarded; clear writes are not.
      OutA <= (wr_acc && (wr_tgt == RdAddrA)) ? WrData : mem[RdAddrA];
      OutB <= (wr_acc && (wr_tgt == RdAddrB)) ? WrData : mem[RdAddrB];
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - self-checking bench for reg_bank (16x8 and 4x12 instances)

module tb_reg_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, wr_inc, clr;
  logic [3:0]  wr_addr, ra, rb;
  logic [7:0]  wr_data;
  logic [7:0]  out_a, out_b;
  logic        busy, clr_done;

  logic        wr_en2, wr_inc2, clr2;
  logic [1:0]  wr_addr2, ra2, rb2;
  logic [11:0] wr_data2;
  logic [11:0] out_a2, out_b2;
  logic        busy2, clr_done2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_bank #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .Reset(rst), .WrEn(wr_en), .WrInc(wr_inc), .WrAddr(wr_addr),
    .WrData(wr_data), .RdAddrA(ra), .RdAddrB(rb), .OutA(out_a), .OutB(out_b),
    .ClrReq(clr), .Busy(busy), .ClrDone(clr_done)
  );

  reg_bank #(.WIDTH(12), .DEPTH(4)) dut2 (
    .clk(clk), .Reset(rst), .WrEn(wr_en2), .WrInc(wr_inc2), .WrAddr(wr_addr2),
    .WrData(wr_data2), .RdAddrA(ra2), .RdAddrB(rb2), .OutA(out_a2), .OutB(out_b2),
    .ClrReq(clr2), .Busy(busy2), .ClrDone(clr_done2)
  );

  // Reference model of the 16x8 instance: plain array plus "index of the
  // next entry the clear will zero" (-1 when no clear is running).
  logic [7:0] m [16];
  int         m_ptr;
  int         m_ci;
  bit         m_done;
  logic [7:0] ea, eb;

  typedef struct {
    bit         we;
    bit         inc;
    logic [3:0] wa;
    logic [7:0] wd;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 0; wr_inc = 0; clr = 0; wr_addr = 0; wr_data = 0; ra = 0; rb = 0;
    wr_en2 = 0; wr_inc2 = 0; clr2 = 0; wr_addr2 = 0; wr_data2 = 0; ra2 = 0; rb2 = 0;
  endtask

  // Advance one clock; the model for the 16-deep instance moves in step.
  task automatic tick();
    int  t;
    bit  mbusy;
    bit  acc;
    if (rst) begin
      for (int i = 0; i < 16; i++) m[i] = '0;
      m_ptr = 0; m_ci = -1; m_done = 0; ea = '0; eb = '0;
    end else begin
      mbusy = (m_ci >= 0);
      acc   = wr_en && !mbusy;
      t     = wr_inc ? m_ptr : int'(wr_addr);
      ea    = (acc && t == int'(ra)) ? wr_data : m[ra];
      eb    = (acc && t == int'(rb)) ? wr_data : m[rb];
      if (acc) m[t] = wr_data;
      if (acc && wr_inc) m_ptr = (m_ptr + 1) % 16;
      if (mbusy) begin
        m[m_ci] = '0;
        m_ci++;
        if (m_ci == 16) begin
          m_ci = -1;
          m_done = 1;
        end
      end else if (m_done) begin
        m_done = 0;
      end else if (clr) begin
        m_ci = 0;
        m_ptr = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill16(input logic [7:0] v);
    for (int a = 0; a < 16; a++) begin
      wr_en = 1; wr_inc = 0; wr_addr = 4'(a); wr_data = v;
      tick();
    end
    idle();
  endtask

  task automatic read_all_zero(input string nm);
    for (int a = 0; a < 16; a++) begin
      ra = 4'(a); rb = 4'(15 - a);
      tick();
      chk({nm, "_a"}, 32'(out_a), 32'h0);
      chk({nm, "_b"}, 32'(out_b), 32'h0);
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bc, dc, bc_at_done;

    vecs[0] = '{1, 0, 4'd3, 8'hA5, 4'd3, 4'd3, 8'hA5, 8'hA5};
    vecs[1] = '{0, 0, 4'd0, 8'h00, 4'd3, 4'd4, 8'hA5, 8'h00};
    vecs[2] = '{1, 0, 4'd0, 8'h11, 4'd0, 4'd3, 8'h11, 8'hA5};
    vecs[3] = '{0, 0, 4'd0, 8'h00, 4'd0, 4'd0, 8'h11, 8'h11};
    vecs[4] = '{1, 0, 4'd5, 8'h3C, 4'd5, 4'd6, 8'h3C, 8'h00};
    vecs[5] = '{0, 0, 4'd0, 8'h00, 4'd5, 4'd3, 8'h3C, 8'hA5};

    idle();
    rst = 1;
    tick();
    rst = 0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(clr_done), 0);
    chk("rst_out_a2", 32'(out_a2), 0);
    read_all_zero("rst_read");

    // Directed write / bypass vectors.
    for (int i = 0; i < 6; i++) begin
      wr_en = vecs[i].we; wr_inc = vecs[i].inc; wr_addr = vecs[i].wa;
      wr_data = vecs[i].wd; ra = vecs[i].a; rb = vecs[i].b;
      tick();
      chk($sformatf("vec%0d_a", i), 32'(out_a), 32'(vecs[i].exp_a));
      chk($sformatf("vec%0d_b", i), 32'(out_b), 32'(vecs[i].exp_b));
    end
    idle();

    // Auto-increment block load of 1..18 wraps the pointer to 2.
    rst = 1; tick(); rst = 0;
    for (int i = 1; i <= 18; i++) begin
      wr_en = 1; wr_inc = 1; wr_data = 8'(i);
      tick();
    end
    idle();
    for (int a = 0; a < 16; a++) begin
      ra = 4'(a);
      tick();
      chk($sformatf("inc_reg%0d", a), 32'(out_a), (a == 0) ? 17 : (a == 1) ? 18 : a + 1);
    end
    wr_en = 1; wr_inc = 1; wr_data = 8'h77; ra = 4'd2; rb = 4'd3;
    tick();
    chk("inc_ptr2_a", 32'(out_a), 32'h77);
    chk("inc_ptr2_b", 32'(out_b), 32'h4);
    idle();

    // Fill with FF, clear, and try writes while Busy.
    fill16(8'hFF);
    clr = 1; wr_en = 1; wr_inc = 1; wr_data = 8'hEE; ra = 4'd0;
    tick();
    idle();
    chk("clr_busy_rise", 32'(busy), 1);
    bc = 0; dc = 0; bc_at_done = -1;
    for (int k = 0; k < 30; k++) begin
      if (busy) begin
        bc++;
        wr_en = 1; wr_inc = k[0]; wr_addr = 4'd9; wr_data = 8'h12;
      end else begin
        wr_en = 0; wr_inc = 0;
      end
      if (clr_done) begin
        dc++;
        bc_at_done = bc;
      end
      tick();
    end
    idle();
    chk("clr_busy_len", bc, 16);
    chk("clr_done_cnt", dc, 1);
    chk("clr_done_when", bc_at_done, 16);
    read_all_zero("clr_read");
    wr_en = 1; wr_inc = 1; wr_data = 8'h66; ra = 4'd0; rb = 4'd1;
    tick();
    chk("clr_ptr0_a", 32'(out_a), 32'h66);
    chk("clr_ptr0_b", 32'(out_b), 32'h0);
    idle();

    // Write alongside ClrReq commits, then is cleared; second request ignored.
    fill16(8'hFF);
    wr_en = 1; wr_addr = 4'd7; wr_data = 8'h5A; clr = 1; ra = 4'd7; rb = 4'd7;
    tick();
    idle();
    chk("cw_bypass", 32'(out_a), 32'h5A);
    ra = 4'd7;
    bc = 0; dc = 0;
    for (int k = 0; k < 30; k++) begin
      clr = (k == 3);
      if (k == 1) chk("cw_old_value", 32'(out_a), 32'h5A);
      if (busy) bc++;
      if (clr_done) dc++;
      tick();
    end
    idle();
    chk("cw_busy_len", bc, 16);
    chk("cw_done_cnt", dc, 1);
    ra = 4'd7;
    tick();
    chk("cw_reg7", 32'(out_a), 32'h0);
    idle();

    // Reset five cycles into CLEAR.
    fill16(8'hFF);
    clr = 1;
    tick();
    idle();
    for (int k = 0; k < 5; k++) tick();
    ra = 4'd15; rb = 4'd14;
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(clr_done), 0);
    chk("mid_rst_out_a", 32'(out_a), 0);
    chk("mid_rst_out_b", 32'(out_b), 0);
    dc = 0;
    for (int k = 0; k < 20; k++) begin
      if (clr_done) dc++;
      tick();
    end
    chk("mid_rst_no_done", dc, 0);
    read_all_zero("mid_rst_read");

    // 4-deep, 12-bit instance.
    wr_en2 = 1; wr_addr2 = 2'd2; wr_data2 = 12'hABC; ra2 = 2'd2; rb2 = 2'd2;
    tick();
    chk("d4_bypass_a", 32'(out_a2), 32'hABC);
    chk("d4_bypass_b", 32'(out_b2), 32'hABC);
    wr_en2 = 0; ra2 = 2'd2; rb2 = 2'd3;
    tick();
    chk("d4_read2", 32'(out_a2), 32'hABC);
    chk("d4_read3", 32'(out_b2), 32'h0);
    for (int i = 1; i <= 5; i++) begin
      wr_en2 = 1; wr_inc2 = 1; wr_data2 = 12'(12'h100 + i);
      tick();
    end
    wr_en2 = 0; wr_inc2 = 0; ra2 = 2'd0; rb2 = 2'd1;
    tick();
    chk("d4_inc_reg0", 32'(out_a2), 32'h105);
    chk("d4_inc_reg1", 32'(out_b2), 32'h102);
    clr2 = 1;
    tick();
    clr2 = 0;
    bc = 0; dc = 0; bc_at_done = -1;
    for (int k = 0; k < 12; k++) begin
      if (busy2) bc++;
      if (clr_done2) begin
        dc++;
        bc_at_done = bc;
      end
      tick();
    end
    chk("d4_busy_len", bc, 4);
    chk("d4_done_cnt", dc, 1);
    chk("d4_done_when", bc_at_done, 4);
    for (int a = 0; a < 4; a++) begin
      ra2 = 2'(a); rb2 = 2'(3 - a);
      tick();
      chk($sformatf("d4_clr_a%0d", a), 32'(out_a2), 0);
      chk($sformatf("d4_clr_b%0d", a), 32'(out_b2), 0);
    end
    idle();

    // Randomised traffic on the 16-deep instance against the model.
    for (int n = 0; n < 800; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      wr_en   = $urandom_range(0, 1);
      wr_inc  = ($urandom_range(0, 2) == 0);
      wr_addr = 4'($urandom);
      wr_data = 8'($urandom);
      ra      = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom);
      rb      = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom);
      clr     = ($urandom_range(0, 24) == 0);
      tick();
      chk("rnd_out_a", 32'(out_a), 32'(ea));
      chk("rnd_out_b", 32'(out_b), 32'(eb));
      chk("rnd_busy", 32'(busy), 32'(m_ci >= 0));
      chk("rnd_done", 32'(clr_done), 32'(m_done));
    end
    rst = 0;
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised register file for the uProcessor datapath, successor to the fixed four-register accumulator file. Holds DEPTH registers of WIDTH bits with one binary-addressed write port, an auto-increment write pointer for block loads, two registered read ports with write-to-read bypass, and a multi-cycle hardware clear sequencer. Sits between the accumulator/ALU result bus and the ALU operand inputs.

## Interface

- WIDTH, default 8: register and data width in bits (≥1).
- DEPTH, default 16: number of registers; power of two, ≥2.
- AW, derived localparam $clog2(DEPTH): address width; not overridable.

- clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset; sampled on rising edge of clk.
- WrEn  in  1  write request.
- WrInc  in  1  with WrEn: write to internal pointer Ptr instead of WrAddr, then increment Ptr.
- WrAddr  in  AW  write address, used when WrInc=0.
- WrData  in  WIDTH  write data.
- RdAddrA  in  AW  read address, port A.
- RdAddrB  in  AW  read address, port B.
- OutA  out  WIDTH  registered read data, port A.
- OutB  out  WIDTH  registered read data, port B.
- ClrReq  in  1  request hardware clear of all registers.
- Busy  out  1  high while clear sequence runs; writes are dropped.
- ClrDone  out  1  one-cycle pulse when clear sequence completes.

## Operation

- Reset (Reset=1 at an edge): all registers, OutA, OutB, Ptr, clear counter ← 0; Busy=0, ClrDone=0; state IDLE. Reset overrides every other input, including mid-clear.
- Write accepted when WrEn=1 and Busy=0. Target = WrInc ? Ptr : WrAddr. reg[target] ← WrData. If WrInc=1, Ptr ← (Ptr+1) mod DEPTH (wraps DEPTH-1 → 0). Dropped writes (Busy=1) change neither registers nor Ptr.
- Read, each port independent, every cycle: OutX ← (write accepted this cycle and target == RdAddrX) ? WrData : reg[RdAddrX]. Both ports may address the same register.
- No register is hardwired; register 0 is writable.
- Clear state machine:
  - IDLE: Busy=0. ClrReq=1 → CLEAR; clear counter ← 0, Ptr ← 0. A write accepted in the same cycle as ClrReq still commits (and is later cleared).
  - CLEAR: Busy=1. Each cycle reg[counter] ← 0, counter ← counter+1. When counter == DEPTH-1 → DONE.
  - DONE: Busy=0, ClrDone=1 for this cycle only → IDLE unconditionally.
  - ClrReq ignored in CLEAR and DONE; no queuing.
- Reads during CLEAR proceed normally: an entry reads its old value until the cycle after its clear write; no bypass of clear writes.
- Writes are accepted again in DONE (Busy=0).

## Timing

- Read latency: 1 cycle (address at edge n → OutX valid after edge n).
- Write-to-read: same-cycle bypass; write at edge n readable on OutX after edge n.
- Busy and ClrDone are registered state decodes: Busy rises one cycle after ClrReq is sampled, stays high exactly DEPTH cycles; ClrDone pulses in the cycle after Busy falls... no: ClrDone asserts in the first cycle Busy is low (DONE state), width 1 cycle.
- ClrReq sampled at edge n → registers fully zero after edge n+DEPTH; ClrDone high between edges n+DEPTH and n+DEPTH+1.
- Reset asserted at any edge: all outputs 0 after that edge.

## Test plan

- Reset, then read all addresses on both ports → OutA=OutB=0 for every address; Busy=0, ClrDone=0.
- WrEn, WrAddr=3, WrData=0xA5 with RdAddrA=3, RdAddrB=3 same cycle → OutA=OutB=0xA5 next cycle (bypass); later read of 3 → 0xA5, address 4 → 0.
- WrInc=1 for DEPTH+2 consecutive writes of values 1..18 (DEPTH=16) → reg0=17, reg1=18, reg2..15=3..16; Ptr=2.
- Fill all 16 with 0xFF, pulse ClrReq → Busy high exactly 16 cycles, ClrDone single pulse, all reads 0 afterwards; writes issued while Busy dropped (target unchanged, Ptr unchanged).
- ClrReq together with write WrAddr=7, WrData=0x5A → after ClrDone reg7=0; second ClrReq during CLEAR → no extra sequence, Busy still 16 cycles.
- Reset asserted 5 cycles into CLEAR → next cycle Busy=0, ClrDone never pulses, all registers and outputs 0; WIDTH=12, DEPTH=4 instance repeats write/bypass/clear checks.
